// File: rtl/axi_dw_rd_scheduler_if.sv
// AR admission / R observation bundle between the slave port, the read scheduler and the converter.
interface axi_dw_rd_scheduler_if #(
  parameter int unsigned MaxReads = 4,
  parameter int unsigned IdWidth  = 4
);
  localparam int unsigned SlotWidth = (MaxReads > 1) ? $clog2(MaxReads) : 1;
  localparam int unsigned CntWidth  = $clog2(MaxReads + 1);

  logic                 slv_ar_valid_i;
  logic                 slv_ar_ready_o;
  logic [IdWidth-1:0]   slv_ar_id_i;
  logic [7:0]           slv_ar_len_i;
  logic                 mst_ar_valid_o;
  logic                 mst_ar_ready_i;
  logic [SlotWidth-1:0] mst_ar_slot_o;
  logic                 r_valid_i;
  logic                 r_ready_i;
  logic [IdWidth-1:0]   r_id_i;
  logic                 r_last_i;
  logic [CntWidth-1:0]  outstanding_o;
  logic                 idle_o;
  logic                 err_last_o;
  logic                 err_id_o;

  modport slave (
    input  slv_ar_valid_i, slv_ar_id_i, slv_ar_len_i, mst_ar_ready_i,
           r_valid_i, r_ready_i, r_id_i, r_last_i,
    output slv_ar_ready_o, mst_ar_valid_o, mst_ar_slot_o,
           outstanding_o, idle_o, err_last_o, err_id_o
  );

  modport master (
    output slv_ar_valid_i, slv_ar_id_i, slv_ar_len_i, mst_ar_ready_i,
           r_valid_i, r_ready_i, r_id_i, r_last_i,
    input  slv_ar_ready_o, mst_ar_valid_o, mst_ar_slot_o,
           outstanding_o, idle_o, err_last_o, err_id_o
  );
endinterface

// File: rtl/axi_dw_rd_scheduler.sv
// Read-path admission controller: allocates tracking slots to ARs, blocks in-flight IDs,
// retires slots on R last and flags beat-count / unknown-ID errors.
module axi_dw_rd_scheduler #(
  parameter  int unsigned MaxReads  = 4,
  parameter  int unsigned IdWidth   = 4,
  localparam int unsigned SlotWidth = (MaxReads > 1) ? $clog2(MaxReads) : 1,
  localparam int unsigned CntWidth  = $clog2(MaxReads + 1)
) (
  input logic clk_i,
  input logic rst_ni,
  axi_dw_rd_scheduler_if.slave bus
);

  logic [MaxReads-1:0]  vld_q;
  logic [IdWidth-1:0]   id_q  [MaxReads];
  logic [7:0]           rem_q [MaxReads];
  logic [CntWidth-1:0]  cnt_q;
  logic                 err_last_q;
  logic                 err_id_q;
  logic                 hold_q;
  logic [SlotWidth-1:0] hold_slot_q;

  logic                 free_found;
  logic [SlotWidth-1:0] free_slot;
  logic                 id_hit;
  logic                 r_hit;
  logic [SlotWidth-1:0] r_idx;
  logic                 admit;
  logic                 ar_valid;
  logic                 ar_hs;
  logic                 r_fire;
  logic                 r_free;
  logic [SlotWidth-1:0] alloc_slot;

  always_comb begin
    free_found = 1'b0;
    free_slot  = '0;
    id_hit     = 1'b0;
    r_hit      = 1'b0;
    r_idx      = '0;
    for (int unsigned i = 0; i < MaxReads; i++) begin
      if (!vld_q[i] && !free_found) begin
        free_found = 1'b1;
        free_slot  = SlotWidth'(i);
      end
      if (vld_q[i] && (id_q[i] == bus.slv_ar_id_i)) id_hit = 1'b1;
      if (vld_q[i] && (id_q[i] == bus.r_id_i)) begin
        r_hit = 1'b1;
        r_idx = SlotWidth'(i);
      end
    end
  end

  // A lower slot may free while a presented AR stalls; pin the offered slot so it stays stable.
  assign alloc_slot = hold_q ? hold_slot_q : free_slot;
  assign admit      = free_found & ~id_hit;
  assign ar_valid   = bus.slv_ar_valid_i & admit;
  assign ar_hs      = ar_valid & bus.mst_ar_ready_i;
  assign r_fire     = bus.r_valid_i & bus.r_ready_i;
  assign r_free     = r_fire & r_hit & bus.r_last_i;

  assign bus.mst_ar_valid_o = ar_valid;
  assign bus.slv_ar_ready_o = bus.mst_ar_ready_i & admit;
  assign bus.mst_ar_slot_o  = alloc_slot;
  assign bus.outstanding_o  = cnt_q;
  assign bus.idle_o         = (cnt_q == '0);
  assign bus.err_last_o     = err_last_q;
  assign bus.err_id_o       = err_id_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q       <= '0;
      for (int unsigned i = 0; i < MaxReads; i++) begin
        id_q[i]  <= '0;
        rem_q[i] <= '0;
      end
      cnt_q       <= '0;
      err_last_q  <= 1'b0;
      err_id_q    <= 1'b0;
      hold_q      <= 1'b0;
      hold_slot_q <= '0;
    end else begin
      err_last_q <= 1'b0;
      err_id_q   <= 1'b0;
      if (ar_hs) begin
        vld_q[alloc_slot] <= 1'b1;
        id_q[alloc_slot]  <= bus.slv_ar_id_i;
        rem_q[alloc_slot] <= bus.slv_ar_len_i;
      end
      if (r_fire) begin
        if (!r_hit) begin
          err_id_q <= 1'b1;
        end else if (bus.r_last_i) begin
          vld_q[r_idx] <= 1'b0;
          err_last_q   <= (rem_q[r_idx] != '0);
        end else if (rem_q[r_idx] == '0) begin
          err_last_q <= 1'b1;
        end else begin
          rem_q[r_idx] <= rem_q[r_idx] - 8'd1;
        end
      end
      hold_q      <= ar_valid & ~bus.mst_ar_ready_i;
      hold_slot_q <= alloc_slot;
      cnt_q       <= cnt_q + CntWidth'(ar_hs) - CntWidth'(r_free);
    end
  end

endmodule

// File: doc/axi_dw_rd_scheduler.md
Name: axi_dw_rd_scheduler

Overview:
- Admission controller and transaction tracker for the read path of the AXI data-width converter.
- Gates slave-port AR requests into the converter and assigns each admitted read a tracking slot; at most MaxReads reads are outstanding.
- Blocks any AR whose ID is already in flight, so the converter never has to reorder same-ID responses.
- Monitors slave-side R beats, retires slots on the last beat, and flags beat-count/ID protocol errors.

Parameters:
- MaxReads, 4, number of tracking slots / maximum outstanding reads (>=1).
- IdWidth, 4, AXI ID width.
- SlotWidth, (MaxReads>1 ? $clog2(MaxReads) : 1), derived; width of the slot index.
- CntWidth, $clog2(MaxReads+1), derived; width of the occupancy count.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- slv_ar_valid_i  in  1  AR valid from slave port.
- slv_ar_ready_o  out  1  AR ready to slave port.
- slv_ar_id_i  in  IdWidth  AR ID.
- slv_ar_len_i  in  8  AR len (beats-1, slave-side width).
- mst_ar_valid_o  out  1  AR valid into the converter.
- mst_ar_ready_i  in  1  AR ready from the converter.
- mst_ar_slot_o  out  SlotWidth  slot allocated to the current AR.
- r_valid_i  in  1  slave-side R valid (observed).
- r_ready_i  in  1  slave-side R ready (observed).
- r_id_i  in  IdWidth  R ID.
- r_last_i  in  1  R last.
- outstanding_o  out  CntWidth  number of occupied slots.
- idle_o  out  1  high when outstanding_o==0.
- err_last_o  out  1  one-cycle pulse on beat-count mismatch.
- err_id_o  out  1  one-cycle pulse on R beat with an unknown ID.

Behaviour:
- Per-slot state: vld (1 bit), id (IdWidth), rem (8 bits, beats remaining minus one).
- Reset (async, rst_ni=0): all vld=0, rem=0, id=0.
  - Outputs during reset: outstanding_o=0, idle_o=1, err_last_o=0, err_id_o=0.
  - slv_ar_ready_o and mst_ar_valid_o follow the combinational rules below, i.e. they pass through with the table empty.
- Reset mid-operation clears all slots immediately; R beats of pre-reset reads are then treated as unknown IDs.
- Admission uses registered state only; same-cycle frees are not visible to it.
  - admit = (some slot has vld=0) AND (no vld slot has id==slv_ar_id_i).
  - mst_ar_valid_o = slv_ar_valid_i & admit.
  - slv_ar_ready_o = mst_ar_ready_i & admit.
  - Zero-latency combinational path; no AR register.
- mst_ar_slot_o = lowest-index slot with vld=0; value is don't-care when full, but it must be stable while mst_ar_valid_o is held.
- On AR handshake (mst_ar_valid_o & mst_ar_ready_i), the chosen slot is loaded with vld=1, id=slv_ar_id_i, rem=slv_ar_len_i.
- AR handshake conditions are unchanged by a same-cycle R event on another slot. Allocating the slot being freed in the same cycle is impossible, because a freed slot is still vld in registered state.
- R tracking runs on each beat where r_valid_i & r_ready_i; match = the vld slot with id==r_id_i (at most one exists by construction). Cases:
  - Match, r_last_i=1, rem==0: slot freed (vld=0); no error.
  - Match, r_last_i=1, rem!=0: slot freed; err_last_o pulses next cycle.
  - Match, r_last_i=0, rem!=0: rem decremented by 1.
  - Match, r_last_i=0, rem==0: rem held at 0, slot stays; err_last_o pulses next cycle.
  - No match: err_id_o pulses next cycle; no state change.
- err_* outputs are registered, high for exactly one cycle per offending beat.
- outstanding_o is the registered popcount of vld. It changes by +1, -1 or 0 (simultaneous alloc and free) per cycle; idle_o = (outstanding_o==0).
- Full condition: outstanding_o==MaxReads forces slv_ar_ready_o=0 and mst_ar_valid_o=0, regardless of ID.
- AR valid stability: the block never drops mst_ar_valid_o once asserted while slv_ar_valid_i holds and no handshake occurred. admit can only go 0 -> 1 without an AR handshake, since slots free but never allocate otherwise.

Test Plan:
- Reset then single read: AR id=3 len=3 -> handshake same cycle, slot 0, outstanding_o=1; four R beats id=3 with last on the 4th -> slot freed, outstanding_o=0, idle_o=1, no errors.
- Fill: 4 ARs ids 0..3 (len=0) -> slots 0,1,2,3, outstanding_o=4; 5th AR id=5 -> slv_ar_ready_o=0; R last id=2 -> next cycle AR id=5 accepted into slot 2.
- Same-ID block: AR id=7 outstanding, second AR id=7 valid -> mst_ar_valid_o=0 until R last id=7 handshake; accepted the following cycle, not the same cycle.
- Simultaneous alloc/free: table holding id 1, AR id=4 handshake in the same cycle as R last id=1 -> outstanding_o unchanged (1), slot 0 freed, slot 1 holds id 4.
- Errors: AR id=2 len=1; R beat id=2 last=1 on first beat -> err_last_o pulse, slot freed; R beat id=9 with no entry -> err_id_o one-cycle pulse, outstanding_o unchanged.
- Async reset with 3 slots occupied and AR stalled -> outstanding_o=0 and idle_o=1 immediately; stalled AR accepted on first cycle after release.
